// File: rtl/frame_pkg.sv
// frame_pkg: shared types and constants for the bitmap frame fetch controller.
//   fetch_state_t   - controller FSM states
//   BYTES_PER_PIXEL - bytes per 24bpp BMP pixel (stored B, G, R)
//   ROW_ALIGN       - BMP row stride alignment in bytes
//   pixel_t         - assembled {R,G,B} pixel
package frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        OUT,
        DONE
    } fetch_state_t;

    localparam int BYTES_PER_PIXEL = 3;
    localparam int ROW_ALIGN       = 4;
    localparam int ALIGN_BITS      = $clog2(ROW_ALIGN);
    localparam int PIX_BITS        = 8 * BYTES_PER_PIXEL;

    typedef logic [PIX_BITS-1:0] pixel_t;

endpackage

// File: rtl/frame_fetch_ctrl_scan_counter.sv
// scan_counter: column/row position tracker for one frame.
//   clk, reset        - clock, synchronous active-high reset
//   i_clear           - restart at x=0, row=0 (frame start)
//   i_step            - advance one pixel (pixel handshake)
//   i_width, i_height - latched frame dimensions
//   o_x, o_y          - current column, image row (bottom-up: height-1-row)
//   o_sol/o_eol       - current pixel starts/ends a line
//   o_sof/o_eof       - current pixel starts/ends the frame
//   o_last            - same as o_eof, used by the FSM to finish
module scan_counter
    import frame_pkg::*;
#(
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic [DIM_W-1:0] i_width,
    input  logic [DIM_W-1:0] i_height,
    output logic [DIM_W-1:0] o_x,
    output logic [DIM_W-1:0] o_y,
    output logic             o_sol,
    output logic             o_eol,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_last
);

    logic [DIM_W-1:0] r_x;
    logic [DIM_W-1:0] r_row;
    logic             w_first_row;
    logic             w_last_row;

    assign w_first_row = (r_row == '0);
    assign w_last_row  = (r_row == i_height - DIM_W'(1));

    assign o_x    = r_x;
    assign o_y    = i_height - DIM_W'(1) - r_row;
    assign o_sol  = (r_x == '0);
    assign o_eol  = (r_x == i_width - DIM_W'(1));
    assign o_sof  = o_sol & w_first_row;
    assign o_eof  = o_eol & w_last_row;
    assign o_last = o_eof;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_x   <= '0;
            r_row <= '0;
        end else if (i_step) begin
            if (o_eol) begin
                r_x   <= '0;
                r_row <= r_row + DIM_W'(1);
            end else begin
                r_x <= r_x + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_fetch_ctrl.sv
// frame_fetch_ctrl: walks a 24bpp BMP pixel array in byte-wide memory and
// hands out one {R,G,B} pixel at a time over valid/ready.
//   clk, reset              - clock, synchronous active-high reset
//   start                   - frame request, honoured in IDLE only
//   width, height, base_addr- frame geometry, latched on accepted start
//   mem_rd, mem_addr        - byte read strobe/address
//   mem_rdata               - read data, valid the cycle after mem_rd
//   pix_valid, pix_ready    - pixel handshake
//   pix_data, pix_x, pix_y  - pixel and its coordinates (y counts down)
//   pix_sol/eol/sof/eof     - line/frame markers, qualified by pix_valid
//   busy                    - frame in progress
//   done                    - one-cycle pulse at frame completion
module frame_fetch_ctrl
    import frame_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int DIM_W   = 16,
    parameter int PIXEL_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DIM_W-1:0]   width,
    input  logic [DIM_W-1:0]   height,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_rdata,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIXEL_W-1:0] pix_data,
    output logic [DIM_W-1:0]   pix_x,
    output logic [DIM_W-1:0]   pix_y,
    output logic               pix_sol,
    output logic               pix_eol,
    output logic               pix_sof,
    output logic               pix_eof,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;

    logic [DIM_W-1:0]  r_width;
    logic [DIM_W-1:0]  r_height;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_b;
    logic              r_rd_d;
    logic [1:0]        r_bidx_d;
    logic [7:0]        r_byte_b;
    logic [7:0]        r_byte_g;
    logic [7:0]        r_byte_r;

    logic              w_accept;
    logic              w_hs;
    pixel_t            w_pix;
    logic [DIM_W-1:0]  w_x;
    logic [DIM_W-1:0]  w_y;
    logic              w_sol;
    logic              w_eol;
    logic              w_sof;
    logic              w_eof;
    logic              w_last;

    assign w_accept = (r_state == IDLE) && start;
    assign w_hs     = (r_state == OUT) && pix_ready;
    assign w_pix    = {r_byte_r, r_byte_g, r_byte_b};

    scan_counter #(
        .DIM_W (DIM_W)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_accept),
        .i_step   (w_hs),
        .i_width  (r_width),
        .i_height (r_height),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_sol    (w_sol),
        .o_eol    (w_eol),
        .o_sof    (w_sof),
        .o_eof    (w_eof),
        .o_last   (w_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = (width == '0 || height == '0) ? DONE : RD;
            RD:   if (r_b == LAST_BYTE) w_state_nxt = CAP;
            CAP:  w_state_nxt = OUT;
            OUT:  if (pix_ready) w_state_nxt = w_last ? DONE : RD;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs; pixel fields are forced to 0 outside OUT so idle outputs
    // never show stale geometry (e.g. height-1 wrapping to all ones).
    always_comb begin
        mem_rd    = 1'b0;
        mem_addr  = '0;
        pix_valid = 1'b0;
        pix_data  = '0;
        pix_x     = '0;
        pix_y     = '0;
        pix_sol   = 1'b0;
        pix_eol   = 1'b0;
        pix_sof   = 1'b0;
        pix_eof   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            RD: begin
                mem_rd   = 1'b1;
                mem_addr = r_addr;
                busy     = 1'b1;
            end
            CAP: busy = 1'b1;
            OUT: begin
                pix_valid = 1'b1;
                pix_data  = PIXEL_W'(w_pix);
                pix_x     = w_x;
                pix_y     = w_y;
                pix_sol   = w_sol;
                pix_eol   = w_eol;
                pix_sof   = w_sof;
                pix_eof   = w_eof;
                busy      = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Address walk and byte capture. Each read's data lands one cycle
    // later, so the byte index is delayed alongside the read strobe; the
    // R byte therefore arrives during CAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_width  <= '0;
            r_height <= '0;
            r_addr   <= '0;
            r_b      <= '0;
            r_rd_d   <= 1'b0;
            r_bidx_d <= '0;
            r_byte_b <= '0;
            r_byte_g <= '0;
            r_byte_r <= '0;
        end else begin
            r_rd_d   <= (r_state == RD);
            r_bidx_d <= r_b;
            if (r_rd_d) begin
                case (r_bidx_d)
                    2'd0:    r_byte_b <= mem_rdata;
                    2'd1:    r_byte_g <= mem_rdata;
                    default: r_byte_r <= mem_rdata;
                endcase
            end
            if (w_accept) begin
                r_width  <= width;
                r_height <= height;
                r_addr   <= base_addr;
                r_b      <= '0;
            end else if (r_state == RD) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_b    <= (r_b == LAST_BYTE) ? 2'd0 : r_b + 2'd1;
            end else if (w_hs && w_eol) begin
                // Row stride is 3*width rounded up to 4: pad = width mod 4
                r_addr <= r_addr + ADDR_W'(r_width[ALIGN_BITS-1:0]);
            end
        end
    end

endmodule

// File: tb/tb_frame_fetch_ctrl.sv
module tb_frame_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] width;
    logic [15:0] height;
    logic [19:0] base_addr;
    logic        mem_rd;
    logic [19:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        pix_sol, pix_eol, pix_sof, pix_eof;
    logic        busy;
    logic        done;

    frame_fetch_ctrl #(.ADDR_W(20), .DIM_W(16), .PIXEL_W(24)) dut (
        .clk(clk), .reset(reset), .start(start),
        .width(width), .height(height), .base_addr(base_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y),
        .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [23:0] d;
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  f;   // {sol,eol,sof,eof}
    } px_t;

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        logic [19:0] base;
        int          hold;
        logic [19:0] pad;
        int          first;
    } frame_t;

    typedef struct {
        logic [23:0] d;
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  f;
        int          cyc;
    } hs_t;

    typedef struct {
        logic [19:0] a;
        int          cyc;
    } rd_t;

    logic [7:0] mem [0:4095];
    px_t        pt [15];
    frame_t     ft [6];
    hs_t        hs_q[$];
    rd_t        rd_q[$];
    int         vq[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         busy_cnt = 0;
    int         checks = 0;
    int         failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[11:0]];

    always @(negedge clk) begin
        if (pix_valid && pix_ready) begin
            hs_t e;
            e.d = pix_data; e.x = pix_x; e.y = pix_y;
            e.f = {pix_sol, pix_eol, pix_sof, pix_eof}; e.cyc = cyc;
            hs_q.push_back(e);
        end
        if (mem_rd) begin
            rd_t r;
            r.a = mem_addr; r.cyc = cyc;
            rd_q.push_back(r);
        end
        if (pix_valid) vq.push_back(cyc);
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_cnt++;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {mem_rd, mem_addr, pix_valid, pix_data, pix_x, pix_y,
                pix_sol, pix_eol, pix_sof, pix_eof, busy, done};
    endfunction

    task automatic run_frame(input int fi);
        frame_t f = ft[fi];
        int h0 = hs_q.size();
        int r0 = rd_q.size();
        int v0 = vq.size();
        int d0 = done_cnt;
        int b0 = busy_cnt;
        int n  = f.w * f.h;
        int t0, bad, nh;
        pix_ready = (f.hold == 0);
        @(posedge clk); #1;
        start = 1'b1; width = f.w; height = f.h; base_addr = f.base; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; width = 16'($urandom); height = 16'($urandom); base_addr = 20'($urandom);
        if (f.hold > 0) begin
            for (int i = 0; i < 50 && !pix_valid; i++) @(negedge clk);
            for (int i = 0; i < f.hold; i++) begin
                if (i > 0) @(negedge clk);
                chk($sformatf("bp_hold%0d", i), {pix_valid, pix_data, mem_rd},
                    {1'b1, pt[f.first].d, 1'b0});
            end
            @(posedge clk); #1 pix_ready = 1'b1;
        end
        for (int i = 0; i < 1000 && done_cnt == d0; i++) @(negedge clk);
        @(negedge clk); @(negedge clk);
        chk($sformatf("f%0d_done_cnt", fi), done_cnt - d0, 1);
        nh = hs_q.size() - h0;
        chk($sformatf("f%0d_hs_cnt", fi), nh, n);
        for (int k = 0; k < n && k < nh; k++) begin
            hs_t e = hs_q[h0 + k];
            px_t p = pt[f.first + k];
            chk($sformatf("f%0d_pix%0d", fi, k), {e.d, e.x, e.y, e.f}, {p.d, p.x, p.y, p.f});
        end
        chk($sformatf("f%0d_rd_cnt", fi), rd_q.size() - r0, 3 * n);
        bad = 0;
        for (int k = r0; k < rd_q.size(); k++) if (rd_q[k].a == f.pad) bad++;
        chk($sformatf("f%0d_pad_read", fi), bad, 0);
        if (n == 0) begin
            chk($sformatf("f%0d_done_cyc", fi), done_cyc, t0 + 1);
            chk($sformatf("f%0d_valid_cnt", fi), vq.size() - v0, 0);
            chk($sformatf("f%0d_busy_cnt", fi), busy_cnt - b0, 0);
        end else if (nh > 0 && rd_q.size() > r0 && vq.size() > v0) begin
            chk($sformatf("f%0d_done_cyc", fi), done_cyc, hs_q[hs_q.size()-1].cyc + 1);
            chk($sformatf("f%0d_first_rd", fi), rd_q[r0].cyc, t0 + 1);
            chk($sformatf("f%0d_first_valid", fi), vq[v0], t0 + 5);
            chk($sformatf("f%0d_busy_seen", fi), busy_cnt - b0 > 0, 1);
            if (f.hold == 0) begin
                bad = 0;
                for (int k = h0 + 1; k < hs_q.size(); k++)
                    if (hs_q[k].cyc - hs_q[k-1].cyc != 5) bad++;
                chk($sformatf("f%0d_spacing", fi), bad, 0);
            end else if (rd_q.size() >= r0 + 4) begin
                chk($sformatf("f%0d_refetch_cyc", fi), rd_q[r0 + 3].cyc, hs_q[h0].cyc + 1);
            end else begin
                chk($sformatf("f%0d_refetch_cyc", fi), 0, 1);
            end
        end else begin
            chk($sformatf("f%0d_no_activity", fi), 0, 1);
        end
    endtask

    initial begin
        int d0, h1, nh;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        mem['h36] = 8'h11; mem['h37] = 8'h22; mem['h38] = 8'h33; mem['h39] = 8'hEE;
        mem['h3A] = 8'h44; mem['h3B] = 8'h55; mem['h3C] = 8'h66;

        // 1x2 with one pad byte per row
        pt[0]  = '{24'h332211, 16'd0, 16'd1, 4'b1110};
        pt[1]  = '{24'h665544, 16'd0, 16'd0, 4'b1101};
        // 4x1 contiguous at 0x100
        pt[2]  = '{24'h020100, 16'd0, 16'd0, 4'b1010};
        pt[3]  = '{24'h050403, 16'd1, 16'd0, 4'b0000};
        pt[4]  = '{24'h080706, 16'd2, 16'd0, 4'b0000};
        pt[5]  = '{24'h0B0A09, 16'd3, 16'd0, 4'b0101};
        // 2x1 at 0x200 with backpressure
        pt[6]  = '{24'h020100, 16'd0, 16'd0, 4'b1010};
        pt[7]  = '{24'h050403, 16'd1, 16'd0, 4'b0101};
        // 3x2 at 0x300: 3 pad bytes, second row starts at 0x30C
        pt[8]  = '{24'h020100, 16'd0, 16'd1, 4'b1010};
        pt[9]  = '{24'h050403, 16'd1, 16'd1, 4'b0000};
        pt[10] = '{24'h080706, 16'd2, 16'd1, 4'b0100};
        pt[11] = '{24'h0E0D0C, 16'd0, 16'd0, 4'b1000};
        pt[12] = '{24'h11100F, 16'd1, 16'd0, 4'b0000};
        pt[13] = '{24'h141312, 16'd2, 16'd0, 4'b0101};
        // 1x1 at 0x600: all four markers
        pt[14] = '{24'h020100, 16'd0, 16'd0, 4'b1111};

        ft[0] = '{16'd1, 16'd2, 20'h00036, 0, 20'h00039, 0};
        ft[1] = '{16'd4, 16'd1, 20'h00100, 0, 20'hFFFFF, 2};
        ft[2] = '{16'd2, 16'd1, 20'h00200, 7, 20'hFFFFF, 6};
        ft[3] = '{16'd3, 16'd2, 20'h00300, 0, 20'h00309, 8};
        ft[4] = '{16'd0, 16'd5, 20'h00500, 0, 20'hFFFFF, 0};
        ft[5] = '{16'd1, 16'd1, 20'h00600, 0, 20'hFFFFF, 14};

        reset = 1'b1; start = 1'b0; width = '0; height = '0; base_addr = '0;
        pix_ready = 1'b1; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_outs", all_outs(), '0);

        for (int fi = 0; fi < 6; fi++) run_frame(fi);

        // Reset during reads of pixel 3 of a 4x4 frame
        d0 = done_cnt; h1 = hs_q.size(); pix_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; width = 16'd4; height = 16'd4; base_addr = 20'h400;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 200 && hs_q.size() - h1 < 3; i++) @(negedge clk);
        for (int i = 0; i < 10 && !mem_rd; i++) @(negedge clk);
        chk("rst_in_rd", mem_rd, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset_outs", all_outs(), '0);
        repeat (8) @(negedge clk);
        chk("midreset_no_done", done_cnt - d0, 0);
        chk("midreset_idle", {busy, mem_rd, pix_valid}, 3'b000);

        // Fresh 4x4 start; a start pulse mid-frame with other geometry is ignored
        h1 = hs_q.size();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 200 && hs_q.size() - h1 < 2; i++) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1; width = 16'd1; height = 16'd1; base_addr = 20'h0;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 1000 && done_cnt == d0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        nh = hs_q.size() - h1;
        chk("replay_hs_cnt", nh, 16);
        chk("replay_done_cnt", done_cnt - d0, 1);
        if (nh >= 16) begin
            chk("replay_pix0", {hs_q[h1].d, hs_q[h1].x, hs_q[h1].y, hs_q[h1].f},
                {24'h020100, 16'd0, 16'd3, 4'b1010});
            chk("replay_pix15", {hs_q[h1+15].d, hs_q[h1+15].x, hs_q[h1+15].y, hs_q[h1+15].f},
                {24'h2F2E2D, 16'd3, 16'd0, 4'b0101});
        end else begin
            chk("replay_pix_present", nh, 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
